// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream controller.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam int unsigned FIFO_DEF_WIDTH = 8;
  // Wide enough to hold buffer occupancy 0..2.
  localparam int unsigned CRED_W = 2;

endpackage

// File: rtl/fifo_rd_stream_skid_buf2.sv
// skid_buf2: 2-entry FIFO-ordered valid/ready buffer; head entry drives the output.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_DEF_WIDTH,
  parameter int unsigned TAG_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CRED_W-1:0] count
);

  localparam int unsigned EW = WIDTH + TAG_W;

  logic [EW-1:0]     e0_q, e0_d, e1_q, e1_d;
  logic [CRED_W-1:0] count_q, count_d;
  logic              pop;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    pop     = (count_q != '0) && out_ready;
    unique case ({in_valid, pop})
      2'b10: begin
        if (count_q == '0) e0_d = {in_tag, in_data};
        else               e1_d = {in_tag, in_data};
        if (count_q != CRED_W'(2)) count_d = count_q + CRED_W'(1);
      end
      2'b01: begin
        e0_d    = e1_q;
        count_d = count_q - CRED_W'(1);
      end
      2'b11: begin
        // Head leaves; incoming word lands behind whatever remains.
        if (count_q == CRED_W'(1)) begin
          e0_d = {in_tag, in_data};
        end else begin
          e0_d = e1_q;
          e1_d = {in_tag, in_data};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= '0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = e0_q[WIDTH-1:0];
  assign out_tag   = e0_q[EW-1:WIDTH];
  assign count     = count_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO controller re-presenting words on a valid/ready stream.
// Optional burst framing (out_last, burst-aligned stop) under FIFO_RD_LAST_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = FIFO_DEF_WIDTH,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_r_data,
  input  logic             fifo_rd_err,
  output logic             fifo_rd_en,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             err
);

  localparam int unsigned BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_e            state_q, state_d;
  logic              inflt_q, inflt_d;
  logic              err_q, err_d;
  logic [BC_W-1:0]   bc_q, bc_d, tag_fl_q, tag_fl_d, buf_tag;
  logic [CRED_W-1:0] count;
  logic [CRED_W:0]   occ;
  logic              pop, rd_allow;

  always_comb begin
    state_d  = state_q;
    bc_d     = bc_q;
    tag_fl_d = bc_q;
    err_d    = err_q | fifo_rd_err;
    pop      = out_valid && out_ready;
    // Occupancy after this cycle's pop, counting the word still in flight.
    occ      = (CRED_W+1)'(count) + (CRED_W+1)'(inflt_q) - (CRED_W+1)'(pop);
`ifdef FIFO_RD_LAST_EN
    rd_allow = (state_q == RUN) || ((state_q == STOP) && (bc_q != '0));
`else
    rd_allow = (state_q == RUN);
`endif
    fifo_rd_en = rd_allow && !fifo_empty && (occ < (CRED_W+1)'(2));
    inflt_d    = fifo_rd_en;
`ifdef FIFO_RD_LAST_EN
    if (fifo_rd_en) bc_d = (bc_q == BC_W'(BURST_LEN - 1)) ? '0 : bc_q + BC_W'(1);
`endif
    unique case (state_q)
      IDLE: if (en) state_d = RUN;
      RUN:  if (!en) state_d = STOP;
      STOP: begin
        if (en) state_d = RUN;
`ifdef FIFO_RD_LAST_EN
        else if (bc_q == '0) state_d = IDLE;
`else
        else state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      inflt_q  <= 1'b0;
      err_q    <= 1'b0;
      bc_q     <= '0;
      tag_fl_q <= '0;
    end else begin
      state_q  <= state_d;
      inflt_q  <= inflt_d;
      err_q    <= err_d;
      bc_q     <= bc_d;
      tag_fl_q <= tag_fl_d;
    end
  end

  skid_buf2 #(
    .WIDTH(WIDTH),
    .TAG_W(BC_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inflt_q),
    .in_data  (fifo_r_data),
    .in_tag   (tag_fl_q),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_tag  (buf_tag),
    .count    (count)
  );

`ifdef FIFO_RD_LAST_EN
  assign out_last = out_valid && (buf_tag == BC_W'(BURST_LEN - 1));
`else
  logic unused_tag;
  assign unused_tag = ^buf_tag;
  assign out_last   = 1'b0;
`endif

  assign busy = (state_q != IDLE) || (count != '0) || inflt_q;
  assign err  = err_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed self-checking bench for fifo_rd_stream with a behavioural FIFO model.
module tb_fifo_rd_stream;

  localparam int W  = 8;
  localparam int BL = 4;

  logic         clk = 1'b0;
  logic         rst, en, fifo_empty, fifo_rd_err, out_ready;
  logic [W-1:0] fifo_r_data;
  logic         fifo_rd_en, out_valid, out_last, busy, err;
  logic [W-1:0] out_data;

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .WIDTH    (W),
    .BURST_LEN(BL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_r_data(fifo_r_data),
    .fifo_rd_err(fifo_rd_err),
    .fifo_rd_en (fifo_rd_en),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] fq[$];
  logic [W-1:0] got_d[$];
  logic         got_l[$];
  int           fire_cyc[$];
  int           acc_cyc[$];
  int           cyc, mcnt;
  logic         prev_fire, stall_prev;
  logic [W-1:0] stall_data;

  task automatic fifo_push(input logic [W-1:0] v);
    fq.push_back(v);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_logs();
    got_d.delete();
    got_l.delete();
    fire_cyc.delete();
    acc_cyc.delete();
  endtask

  // One clock: sample and check at negedge, then advance the FIFO model after posedge.
  task automatic tick();
    logic fire, pop;
    @(negedge clk);
    cyc++;
    fire = fifo_rd_en;
    pop  = out_valid && out_ready;
    if (!rst) begin
      chk("valid_vs_count", 32'(out_valid), 32'(mcnt > 0));
      chk("credit_ovf", 32'(prev_fire && (mcnt == 2) && !pop), 32'd0);
      if (stall_prev) begin
        chk("stall_data", 32'(out_data), 32'(stall_data));
        chk("stall_valid", 32'(out_valid), 32'd1);
      end
    end
`ifndef FIFO_RD_LAST_EN
    chk("last_tied0", 32'(out_last), 32'd0);
`endif
    if (fire) fire_cyc.push_back(cyc);
    if (pop) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
      acc_cyc.push_back(cyc);
    end
    stall_prev = out_valid && !out_ready && !rst;
    stall_data = out_data;
    @(posedge clk);
    #1;
    if (rst) begin
      fq.delete();
      mcnt       = 0;
      prev_fire  = 1'b0;
      stall_prev = 1'b0;
    end else begin
      mcnt = mcnt + (prev_fire ? 1 : 0) - (pop ? 1 : 0);
      if (fire && fq.size() > 0) fifo_r_data = fq.pop_front();
      prev_fire = fire;
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    en          = 1'b0;
    out_ready   = 1'b0;
    fifo_rd_err = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
  endtask

  initial begin
    int c0;
    cyc = 0; mcnt = 0; prev_fire = 1'b0; stall_prev = 1'b0; stall_data = '0;
    fifo_empty = 1'b1; fifo_r_data = '0;

    // Streaming at full rate
    do_reset();
    clear_logs();
    for (int i = 0; i < 8; i++) fifo_push(W'(8'h11 + i));
    en = 1'b1; out_ready = 1'b1;
    c0 = cyc;
    repeat (16) tick();
    chk("t1_nreads", 32'(fire_cyc.size()), 32'd8);
    chk("t1_nbeats", 32'(got_d.size()), 32'd8);
    if (fire_cyc.size() == 8 && got_d.size() == 8) begin
      chk("t1_first_rd", 32'(fire_cyc[0]), 32'(c0 + 2));
      chk("t1_rd_consec", 32'(fire_cyc[7] - fire_cyc[0]), 32'd7);
      for (int i = 0; i < 8; i++) begin
        chk("t1_data", 32'(got_d[i]), 32'(8'h11 + i));
        chk("t1_lat", 32'(acc_cyc[i]), 32'(fire_cyc[0] + 2 + i));
      end
    end
    en = 1'b0;
    repeat (3) tick();
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // Back-pressure with out_ready toggling
    do_reset();
    clear_logs();
    for (int i = 0; i < 8; i++) fifo_push(W'(8'h11 + i));
    en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      out_ready = (k % 2 == 0);
      tick();
    end
    chk("t2_nbeats", 32'(got_d.size()), 32'd8);
    if (got_d.size() == 8)
      for (int i = 0; i < 8; i++) chk("t2_data", 32'(got_d[i]), 32'(8'h11 + i));
    en = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("t2_idle_busy", 32'(busy), 32'd0);

    // Stalled consumer: only two reads fit in the buffer
    do_reset();
    clear_logs();
    for (int i = 0; i < 5; i++) fifo_push(W'(8'h31 + i));
    en = 1'b1; out_ready = 1'b0;
    repeat (8) tick();
    chk("t3_nreads", 32'(fire_cyc.size()), 32'd2);
    chk("t3_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_head", 32'(out_data), 32'h31);
    chk("t3_fifo_left", 32'(fq.size()), 32'd3);

    // Reset while full and with a read in flight
    out_ready = 1'b1;
    tick();
    chk("t4_refill_rd", 32'(fire_cyc.size()), 32'd3);
    out_ready = 1'b0; rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_rd_en", 32'(fifo_rd_en), 32'd0);
    clear_logs();
    out_ready = 1'b1;
    repeat (4) tick();
    chk("t4_no_stale", 32'(got_d.size()), 32'd0);
    chk("t4_valid_after", 32'(out_valid), 32'd0);

    // Sticky error
    fifo_rd_err = 1'b1;
    tick();
    fifo_rd_err = 1'b0;
    chk("t5_err_set", 32'(err), 32'd1);
    repeat (5) tick();
    chk("t5_err_hold", 32'(err), 32'd1);
    do_reset();

`ifdef FIFO_RD_LAST_EN
    // Burst framing: stop requested mid-burst finishes the burst
    clear_logs();
    for (int i = 0; i < 6; i++) fifo_push(W'(8'h21 + i));
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 40 && got_d.size() < 5; i++) tick();
    chk("b_beat5", 32'(got_d.size() >= 5), 32'd1);
    en = 1'b0;
    repeat (6) tick();
    chk("b_wait_reads", 32'(fire_cyc.size()), 32'd6);
    chk("b_stop_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) fifo_push(W'(8'h27 + i));
    repeat (8) tick();
    chk("b_nreads", 32'(fire_cyc.size()), 32'd8);
    chk("b_fifo_left", 32'(fq.size()), 32'd1);
    chk("b_nbeats", 32'(got_d.size()), 32'd8);
    if (got_d.size() == 8)
      for (int i = 0; i < 8; i++) begin
        chk("b_data", 32'(got_d[i]), 32'(8'h21 + i));
        chk("b_last", 32'(got_l[i]), 32'(i == 3 || i == 7));
      end
    chk("b_idle", 32'(busy), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
